// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver / host side and the receive FIFO.
// The master modport drives the bytes and pop requests, and the slave modport is the FIFO.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic            rx_done;
  logic            rx_err;
  logic [7:0]      rx_data;
  logic            rd_en;
  logic            clr_ovf;
  logic [7:0]      rd_data;
  logic            rd_err;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [7:0]      err_cnt;

  modport master (
    output rx_done, rx_err, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_err, empty, full, count, overflow, err_cnt
  );

  modport slave (
    input  rx_done, rx_err, rx_data, rd_en, clr_ovf,
    output rd_data, rd_err, empty, full, count, overflow, err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind uart_rx_top. A new entry is written on each rising edge of rx_done.
// The module also keeps a sticky overflow flag and a saturating framing-error counter.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DROP_ERR = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  uart_rx_fifo_if.slave     bus
);

  localparam logic [ADDR_W:0] LP_FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [8:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_rxDoneQ;
  logic              r_overflow;
  logic [7:0]        r_errCnt;

  logic              w_pushReq;
  logic              w_errDrop;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_ovfSet;
  logic [8:0]        w_head;

  assign w_pushReq = bus.rx_done & ~r_rxDoneQ;
  assign w_errDrop = (DROP_ERR != 0) & bus.rx_err;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_FULL_CNT);
  assign w_pop     = bus.rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still succeeds.
  assign w_push    = w_pushReq & ~w_errDrop & (~w_full | w_pop);
  assign w_ovfSet  = w_pushReq & ~w_errDrop & w_full & ~w_pop;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rxDoneQ  <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_errCnt   <= 8'd0;
    end else begin
      r_rxDoneQ <= bus.rx_done;

      if (w_push) r_wrPtr <= r_wrPtr + ADDR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + ADDR_W'(1);

      if (w_push && !w_pop)      r_count <= r_count + (ADDR_W + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (ADDR_W + 1)'(1);

      // Set takes priority over clear so that a byte lost in the same cycle is never hidden.
      if (w_ovfSet)         r_overflow <= 1'b1;
      else if (bus.clr_ovf) r_overflow <= 1'b0;

      if (w_pushReq && bus.rx_err && (r_errCnt != 8'hFF))
        r_errCnt <= r_errCnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {bus.rx_err, bus.rx_data};
  end

  assign w_head = r_mem[r_rdPtr];

  assign bus.rd_data  = w_empty ? 8'h00 : w_head[7:0];
  assign bus.rd_err   = w_empty ? 1'b0  : w_head[8];
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.err_cnt  = r_errCnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Two instances (DROP_ERR=0 and 1) share the same stimulus.
// Each instance is compared every cycle against a queue-based model and against hand-computed values.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic       clk = 1'b0;
  logic       arstN;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxData;
  logic       rdEn;
  logic       clrOvf;
  bit         compareOn = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  logic [8:0] mq [2][$];
  int         errM [2];
  bit         ovfM [2];
  bit         mDoneQ;

  logic [ADDR_W:0] aCount [2];
  logic [7:0]      aRdData [2];
  logic            aRdErr [2];
  logic            aEmpty [2];
  logic            aFull [2];
  logic            aOvf [2];
  logic [7:0]      aErrCnt [2];

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) ifc0 ();
  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) ifc1 ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_ERR(0)) dut0 (
    .clk    (clk),
    .arst_n (arstN),
    .bus    (ifc0)
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_ERR(1)) dut1 (
    .clk    (clk),
    .arst_n (arstN),
    .bus    (ifc1)
  );

  always #5 clk = ~clk;

  assign ifc0.rx_done = rxDone;
  assign ifc0.rx_err  = rxErr;
  assign ifc0.rx_data = rxData;
  assign ifc0.rd_en   = rdEn;
  assign ifc0.clr_ovf = clrOvf;
  assign ifc1.rx_done = rxDone;
  assign ifc1.rx_err  = rxErr;
  assign ifc1.rx_data = rxData;
  assign ifc1.rd_en   = rdEn;
  assign ifc1.clr_ovf = clrOvf;

  assign aCount[0]  = ifc0.count;
  assign aCount[1]  = ifc1.count;
  assign aRdData[0] = ifc0.rd_data;
  assign aRdData[1] = ifc1.rd_data;
  assign aRdErr[0]  = ifc0.rd_err;
  assign aRdErr[1]  = ifc1.rd_err;
  assign aEmpty[0]  = ifc0.empty;
  assign aEmpty[1]  = ifc1.empty;
  assign aFull[0]   = ifc0.full;
  assign aFull[1]   = ifc1.full;
  assign aOvf[0]    = ifc0.overflow;
  assign aOvf[1]    = ifc1.overflow;
  assign aErrCnt[0] = ifc0.err_cnt;
  assign aErrCnt[1] = ifc1.err_cnt;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    mDoneQ = 1'b0;
    for (int v = 0; v < 2; v++) begin
      mq[v].delete();
      errM[v] = 0;
      ovfM[v] = 1'b0;
    end
  endtask

  // One clock edge of the FIFO rules: rising-edge push, error counting, drop/overflow, then pop-before-push ordering.
  task automatic modelStep();
    bit pushReq;
    bit popOk;
    bit wasFull;
    bit store;
    pushReq = rxDone && !mDoneQ;
    mDoneQ  = rxDone;
    for (int v = 0; v < 2; v++) begin
      popOk   = rdEn && (mq[v].size() != 0);
      wasFull = (mq[v].size() == DEPTH);
      store   = pushReq && !(v == 1 && rxErr);
      if (pushReq && rxErr && errM[v] < 255) errM[v]++;
      if (clrOvf) ovfM[v] = 1'b0;
      if (store && wasFull && !popOk) ovfM[v] = 1'b1;
      if (popOk) void'(mq[v].pop_front());
      if (store && (!wasFull || popOk)) mq[v].push_back({rxErr, rxData});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (arstN) modelStep();
    else       modelReset();
    #1;
  endtask

  task automatic applyStimulus(input logic done, input logic err, input logic [7:0] data,
                               input logic rd, input logic clr, input int n);
    rxDone = done;
    rxErr  = err;
    rxData = data;
    rdEn   = rd;
    clrOvf = clr;
    repeat (n) cycle();
  endtask

  always @(negedge clk) begin : cmp
    int         sz;
    logic [8:0] hd;
    if (compareOn) begin
      for (int v = 0; v < 2; v++) begin
        sz = mq[v].size();
        hd = (sz != 0) ? mq[v][0] : 9'd0;
        checkOutput($sformatf("model_count%0d", v),  int'(aCount[v]),  sz);
        checkOutput($sformatf("model_empty%0d", v),  int'(aEmpty[v]),  int'(sz == 0));
        checkOutput($sformatf("model_full%0d", v),   int'(aFull[v]),   int'(sz == DEPTH));
        checkOutput($sformatf("model_rddata%0d", v), int'(aRdData[v]), int'(hd[7:0]));
        checkOutput($sformatf("model_rderr%0d", v),  int'(aRdErr[v]),  int'(hd[8]));
        checkOutput($sformatf("model_ovf%0d", v),    int'(aOvf[v]),    int'(ovfM[v]));
        checkOutput($sformatf("model_errcnt%0d", v), int'(aErrCnt[v]), errM[v]);
      end
    end
  end

  initial begin
    rxDone = 1'b0;
    rxErr  = 1'b0;
    rxData = 8'h00;
    rdEn   = 1'b0;
    clrOvf = 1'b0;
    arstN  = 1'b0;
    modelReset();
    repeat (3) cycle();
    arstN = 1'b1;
    compareOn = 1'b1;

    for (int v = 0; v < 2; v++) begin
      checkOutput($sformatf("rst_count%0d", v),  int'(aCount[v]),  0);
      checkOutput($sformatf("rst_empty%0d", v),  int'(aEmpty[v]),  1);
      checkOutput($sformatf("rst_full%0d", v),   int'(aFull[v]),   0);
      checkOutput($sformatf("rst_rddata%0d", v), int'(aRdData[v]), 0);
      checkOutput($sformatf("rst_ovf%0d", v),    int'(aOvf[v]),    0);
      checkOutput($sformatf("rst_errcnt%0d", v), int'(aErrCnt[v]), 0);
    end

    $display("[TB] single byte");
    applyStimulus(1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 1);
    checkOutput("single_count",  int'(aCount[0]),  1);
    checkOutput("single_empty",  int'(aEmpty[0]),  0);
    checkOutput("single_rddata", int'(aRdData[0]), 8'h0F);
    checkOutput("single_rderr",  int'(aRdErr[0]),  0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    checkOutput("single_pop_empty",  int'(aEmpty[0]),  1);
    checkOutput("single_pop_count",  int'(aCount[0]),  0);
    checkOutput("single_pop_rddata", int'(aRdData[0]), 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);

    $display("[TB] level rx_done");
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 50);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    checkOutput("level_count",  int'(aCount[0]),  1);
    checkOutput("level_rddata", int'(aRdData[0]), 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    end
    checkOutput("fill_full",  int'(aFull[0]),  1);
    checkOutput("fill_count", int'(aCount[0]), 16);
    checkOutput("fill_ovf",   int'(aOvf[0]),   0);
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    checkOutput("ovf_set",    int'(aOvf[0]),    1);
    checkOutput("ovf_count",  int'(aCount[0]),  16);
    checkOutput("ovf_rddata", int'(aRdData[0]), 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    checkOutput("ovf_clr", int'(aOvf[0]), 0);

    $display("[TB] push and pop at full");
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1);
    checkOutput("fullpp_count",  int'(aCount[0]),  16);
    checkOutput("fullpp_ovf",    int'(aOvf[0]),    0);
    checkOutput("fullpp_rddata", int'(aRdData[0]), 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    for (int i = 1; i < 16; i++) begin
      checkOutput($sformatf("drain_%0d", i), int'(aRdData[0]), i);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    end
    checkOutput("drain_last", int'(aRdData[0]), 8'h55);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    checkOutput("drain_empty", int'(aEmpty[0]), 1);

    $display("[TB] push and pop at empty");
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1);
    checkOutput("emptypp_count",  int'(aCount[0]),  1);
    checkOutput("emptypp_rddata", int'(aRdData[0]), 8'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);

    $display("[TB] error bytes");
    applyStimulus(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    checkOutput("err_rddata0", int'(aRdData[0]), 8'h12);
    checkOutput("err_rderr0",  int'(aRdErr[0]),  1);
    checkOutput("err_cnt0",    int'(aErrCnt[0]), 1);
    checkOutput("err_empty1",  int'(aEmpty[1]),  1);
    checkOutput("err_cnt1",    int'(aErrCnt[1]), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    end
    checkOutput("errsat_cnt0",  int'(aErrCnt[0]), 255);
    checkOutput("errsat_cnt1",  int'(aErrCnt[1]), 255);
    checkOutput("errsat_full0", int'(aFull[0]),   1);
    checkOutput("errsat_ovf0",  int'(aOvf[0]),    1);
    checkOutput("errsat_ovf1",  int'(aOvf[1]),    0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 11);
    rdEn = 1'b0;
    checkOutput("mid_count_before", int'(aCount[0]), 5);
    #2;
    arstN = 1'b0;
    modelReset();
    #1;
    checkOutput("mid_count",  int'(aCount[0]),  0);
    checkOutput("mid_empty",  int'(aEmpty[0]),  1);
    checkOutput("mid_ovf",    int'(aOvf[0]),    0);
    checkOutput("mid_errcnt", int'(aErrCnt[0]), 0);
    checkOutput("mid_rddata", int'(aRdData[0]), 0);
    applyStimulus(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 2);
    arstN = 1'b1;
    cycle();
    checkOutput("release_count0",  int'(aCount[0]),  1);
    checkOutput("release_count1",  int'(aCount[1]),  1);
    checkOutput("release_rddata0", int'(aRdData[0]), 8'hC3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 2500; n++) begin
      rxDone = ($urandom_range(0, 2) == 0);
      rxErr  = ($urandom_range(0, 7) == 0);
      rxData = 8'($urandom);
      rdEn   = (n < 1200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      clrOvf = ($urandom_range(0, 19) == 0);
      cycle();
    end

    compareOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
